conv_3x3: RTL
=============

CONV_3X3 -- requirements
Module: conv_3x3

Interface
REQ-001 Parameter HRES, default 320, pixels per line.
REQ-002 Parameter VRES, default 240, lines per frame.
REQ-003 clk_in  input  1  system clock; single clock domain.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 line_buffer_in  input  [2:0][6:0]  one column of three rows: [2] = row above centre, [1] = centre, [0] = row below.
REQ-006 hcount_in  input  11  column of the line_buffer_in column.
REQ-007 vcount_in  input  10  row of line_buffer_in[1].
REQ-008 data_valid_in  input  1  column valid this cycle.
REQ-009 kernel_select_in  input  2  0 identity, 1 gaussian, 2 sharpen, 3 sobel.
REQ-010 pixel_out  output  7  filtered centre pixel.
REQ-011 hcount_out  output  11  column of pixel_out.
REQ-012 vcount_out  output  10  row of pixel_out.
REQ-013 data_valid_out  output  1  pixel_out valid.
REQ-014 overrun_out  output  1  sticky protocol-error flag.

Function
REQ-015 Window shall be three registered columns W0 (oldest), W1 (centre), W2 (newest), shifted on each data_valid_in.
REQ-016 On valid input with hcount_in==0, W0, W1 and W2 shall all load the incoming column (left-edge replication), with no output generated.
REQ-017 On valid input with 1<=hcount_in<=HRES-1, an output for centre column hcount_in-1 shall be emitted exactly 3 cycles later.
REQ-018 In the cycle after a valid input with hcount_in==HRES-1, a flush shall shift W2 into W1 and keep W2 (right-edge replication), emitting column HRES-1 at 3 cycles after the flush cycle (4 cycles after the input).
REQ-019 A data_valid_in in the flush cycle shall be dropped and shall set overrun_out, which stays set until reset.
REQ-020 Vertical edges: when the centre row is 0, row [2] shall be replaced by row [1]; when it is VRES-1, row [0] shall be replaced by row [1].
REQ-021 Gaussian: weights 1 2 1 / 2 4 2 / 1 2 1, sum >>4 (truncate).
REQ-022 Sharpen: weights 0 -1 0 / -1 5 -1 / 0 -1 0, clamped to 0..127.
REQ-023 Sobel: |Gx|+|Gy| using the standard 3x3 Sobel kernels, clamped to 0..127.
REQ-024 Identity: output equals the centre pixel.
REQ-025 Accumulation shall be 12-bit signed; no intermediate overflow is permitted.
REQ-026 Pipeline stages: S1 edge-muxed window register; S2 weighted row partial sums; S3 final sum, shift/abs/clamp, output register.
REQ-027 hcount_out, vcount_out and data_valid_out shall travel with the pixel through S1-S3, aligned to pixel_out.
REQ-028 kernel_select_in shall be sampled only on valid input with hcount_in==0 and vcount_in==0; the sampled kernel applies for the whole frame.
REQ-029 data_valid_out shall be low on every cycle that has no emitted output; pixel_out is don't-care then, but shall hold its last value.

Reset
REQ-030 While rst_in is high, pixel_out, hcount_out, vcount_out, data_valid_out and overrun_out shall be 0; window and pipeline valids shall clear; the latched kernel shall be identity.
REQ-031 Reset asserted mid-line shall discard all in-flight outputs; no data_valid_out shall occur until a new hcount_in==0 column arrives.

Structure
REQ-032 Package conv_pkg shall hold the kernel_t enum (IDENT, GAUSS, SHARP, SOBEL), the pixel width (7) and the accumulator width (12).
REQ-033 Weighted-sum/clamp arithmetic shall be sub-module conv_kernel_mac (S2-S3); windowing, flush, edge handling and tag pipeline stay in conv_3x3.

Verification
REQ-034 Identity test: HRES=8, ramp pixel=hcount, one line at vcount 5 -> outputs 0..7 in order; each output 3 cycles after input x+1; column 7 output 4 cycles after the hcount 7 input.
REQ-035 Uniform test: all pixels 100, gaussian -> every output is 100, including every corner and edge.
REQ-036 Sharpen clamp test: centre 127, neighbours 0 -> 127. Centre 0, neighbours 127 -> 0.
REQ-037 Sobel test: vertical step, left columns 0, right columns 127 -> 127 at the step and 0 in flat regions.
REQ-038 Overrun test: valid asserted in the cycle after hcount HRES-1 -> overrun_out=1, that column is dropped, flush output is still correct; rst_in clears the flag.
REQ-039 Mid-frame test: kernel_select_in changed mid-frame -> no effect until the next (0,0) pixel; rst_in pulsed mid-line -> outputs 0 at once and no spurious data_valid_out.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types, widths and the saturating pixel clamp for the 3x3 convolution block.
package conv_pkg;
  localparam int PIX_W = 7;
  localparam int ACC_W = 12;

  typedef enum logic [1:0] {
    IDENT = 2'd0,
    GAUSS = 2'd1,
    SHARP = 2'd2,
    SOBEL = 2'd3
  } kernel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH
  } line_state_t;

  typedef logic [2:0][PIX_W-1:0] col_t;
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

  localparam logic signed [ACC_W-1:0] PIX_MAX = 12'sd127;

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1]) return '0;
    if (v > PIX_MAX) return 7'd127;
    return v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/conv_kernel_mac.sv
// Weighted 3x3 sums: S2 forms per-row/per-column partials, S3 combines, shifts/abs/clamps.
module conv_kernel_mac import conv_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             s2_en,
  input  logic             s3_en,
  input  kernel_t          kern_s1,
  input  kernel_t          kern_s2,
  input  win_t             win,
  output logic [PIX_W-1:0] pix_out
);
  logic signed [ACC_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [ACC_W-1:0] row_top, row_mid, row_bot, col_lft, col_rgt, sum_g;
  logic [PIX_W-1:0]        pix_q, pix_d, res;

  function automatic logic signed [ACC_W-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({{(ACC_W-PIX_W){1'b0}}, p});
  endfunction

  function automatic logic signed [ACC_W-1:0] mag(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] ? -v : v;
  endfunction

  // win[column][row]: column 0 is leftmost, row 2 is above the centre.
  always_comb begin
    row_top = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]);
    row_mid = ext(win[0][1]) + (ext(win[1][1]) <<< 1) + ext(win[2][1]);
    row_bot = ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]);
    col_lft = ext(win[0][2]) + (ext(win[0][1]) <<< 1) + ext(win[0][0]);
    col_rgt = ext(win[2][2]) + (ext(win[2][1]) <<< 1) + ext(win[2][0]);
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (s2_en) begin
      case (kern_s1)
        IDENT: begin
          a_d = ext(win[1][1]);
          b_d = '0;
          c_d = '0;
        end
        GAUSS: begin
          a_d = row_top;
          b_d = row_mid;
          c_d = row_bot;
        end
        SHARP: begin
          a_d = (ext(win[1][1]) <<< 2) + ext(win[1][1]) - ext(win[0][1]) - ext(win[2][1]);
          b_d = -(ext(win[1][2]) + ext(win[1][0]));
          c_d = '0;
        end
        default: begin
          a_d = col_rgt - col_lft;
          b_d = row_top - row_bot;
          c_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    sum_g = (a_q + (b_q <<< 1) + c_q) >>> 4;
    case (kern_s2)
      IDENT:   res = clamp_pix(a_q);
      GAUSS:   res = clamp_pix(sum_g);
      SHARP:   res = clamp_pix(a_q + b_q);
      default: res = clamp_pix(mag(a_q) + mag(b_q));
    endcase
    pix_d = s3_en ? res : pix_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      pix_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      pix_q <= pix_d;
    end
  end

  assign pix_out = pix_q;
endmodule

// File: rtl/conv_3x3.sv
// 3x3 streaming convolution: column window with edge replication, end-of-line flush,
// tag pipeline aligned to the MAC, and a sticky overrun flag.
module conv_3x3 import conv_pkg::*; #(
  parameter int HRES = 320,
  parameter int VRES = 240
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [2:0][PIX_W-1:0] line_buffer_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic                  data_valid_in,
  input  logic [1:0]            kernel_select_in,
  output logic [PIX_W-1:0]      pixel_out,
  output logic [10:0]           hcount_out,
  output logic [9:0]            vcount_out,
  output logic                  data_valid_out,
  output logic                  overrun_out
);
  localparam logic [10:0] H_LAST = 11'(HRES - 1);
  localparam logic [9:0]  V_LAST = 10'(VRES - 1);

  line_state_t state_q, state_d;
  logic        load_all, shift_en, flush_en, ovr_set;
  col_t        col_m, w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  win_t        win;
  kernel_t     kern_q, kern_d, s1_kern_q, s1_kern_d, s2_kern_q;
  logic        s1_valid_q, s1_valid_d, s2_valid_q, dv_q;
  logic [10:0] s1_h_q, s1_h_d, s2_h_q, hout_q, hout_d;
  logic [9:0]  s1_v_q, s1_v_d, s2_v_q, vout_q, vout_d;
  logic        ovr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (data_valid_in && hcount_in == 11'd0) state_d = ST_ACTIVE;
      ST_ACTIVE: if (data_valid_in && hcount_in == H_LAST) state_d = ST_FLUSH;
      ST_FLUSH:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Without a line start (IDLE) the window is stale, so mid-line columns are ignored.
  always_comb begin
    load_all = 1'b0;
    shift_en = 1'b0;
    flush_en = 1'b0;
    ovr_set  = 1'b0;
    case (state_q)
      ST_IDLE:   load_all = data_valid_in && (hcount_in == 11'd0);
      ST_ACTIVE: begin
        if (data_valid_in) begin
          if (hcount_in == 11'd0)      load_all = 1'b1;
          else if (hcount_in <= H_LAST) shift_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_en = 1'b1;
        ovr_set  = data_valid_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    col_m    = line_buffer_in;
    col_m[2] = (vcount_in == 10'd0) ? line_buffer_in[1] : line_buffer_in[2];
    col_m[0] = (vcount_in == V_LAST) ? line_buffer_in[1] : line_buffer_in[0];

    w0_d       = w0_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    s1_valid_d = 1'b0;
    s1_h_d     = s1_h_q;
    s1_v_d     = s1_v_q;
    s1_kern_d  = s1_kern_q;
    kern_d     = kern_q;
    if (load_all) begin
      w0_d = col_m;
      w1_d = col_m;
      w2_d = col_m;
      if (vcount_in == 10'd0) kern_d = kernel_t'(kernel_select_in);
    end
    if (shift_en) begin
      w0_d       = w1_q;
      w1_d       = w2_q;
      w2_d       = col_m;
      s1_valid_d = 1'b1;
      s1_h_d     = hcount_in - 11'd1;
      s1_v_d     = vcount_in;
      s1_kern_d  = kern_q;
    end
    // Flush keeps W2 as the right neighbour of the last column.
    if (flush_en) begin
      w0_d       = w1_q;
      w1_d       = w2_q;
      s1_valid_d = 1'b1;
      s1_h_d     = H_LAST;
    end

    hout_d = hout_q;
    vout_d = vout_q;
    if (s2_valid_q) begin
      hout_d = s2_h_q;
      vout_d = s2_v_q;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      w0_q       <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      kern_q     <= IDENT;
      s1_valid_q <= 1'b0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
      s1_kern_q  <= IDENT;
      s2_valid_q <= 1'b0;
      s2_h_q     <= '0;
      s2_v_q     <= '0;
      s2_kern_q  <= IDENT;
      dv_q       <= 1'b0;
      hout_q     <= '0;
      vout_q     <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      kern_q     <= kern_d;
      s1_valid_q <= s1_valid_d;
      s1_h_q     <= s1_h_d;
      s1_v_q     <= s1_v_d;
      s1_kern_q  <= s1_kern_d;
      s2_valid_q <= s1_valid_q;
      s2_h_q     <= s1_h_q;
      s2_v_q     <= s1_v_q;
      s2_kern_q  <= s1_kern_q;
      dv_q       <= s2_valid_q;
      hout_q     <= hout_d;
      vout_q     <= vout_d;
      ovr_q      <= ovr_q | ovr_set;
    end
  end

  assign win = {w2_q, w1_q, w0_q};

  conv_kernel_mac u_mac (
    .clk     (clk_in),
    .rst     (rst_in),
    .s2_en   (s1_valid_q),
    .s3_en   (s2_valid_q),
    .kern_s1 (s1_kern_q),
    .kern_s2 (s2_kern_q),
    .win     (win),
    .pix_out (pixel_out)
  );

  assign hcount_out     = hout_q;
  assign vcount_out     = vout_q;
  assign data_valid_out = dv_q;
  assign overrun_out    = ovr_q;
endmodule
